// File: rtl/rect_streamer.sv
// Rectangle table streamer: resets the GPU loader, kicks a copy, then reads the
// 64-entry rectangle table from data memory and presents each word to the GPU
// on its capture slot, with a zero word in every sixth (gap) slot.
module rect_streamer #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           RECT_COUNT = 64
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  gpu_reset,
    output logic                  copy_start,
    output logic [15:0]           data_out,
    output logic                  busy,
    output logic                  done
);

    // Cycle offset from the start-sample cycle; the last capture lands on 6*RECT_COUNT+2.
    localparam int unsigned       CycW    = $clog2(6 * RECT_COUNT + 3);
    localparam int unsigned       RectW   = $clog2(RECT_COUNT + 1);
    localparam logic [CycW-1:0]   LastCyc = CycW'(6 * RECT_COUNT + 2);
    localparam logic [RectW-1:0]  RectEnd = RectW'(RECT_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StGpuRst,
        StKick,
        StStream
    } state_e;

    state_e                  state_q;
    logic [CycW-1:0]         cyc_q;
    logic [RectW-1:0]        rect_q;   // rect whose word is read in the next cycle
    logic [2:0]              slot_q;   // word index read in the next cycle; 5 = gap
    logic [ADDR_WIDTH-1:0]   ptr_q;    // next table address to read
    logic                    rd_en_d_q;

    // Control FSM with registered outputs; every output is set for the following cycle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            rect_q     <= '0;
            slot_q     <= '0;
            ptr_q      <= '0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            gpu_reset  <= 1'b0;
            copy_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done       <= 1'b0;
                    mem_rd_en  <= 1'b0;
                    mem_addr   <= '0;
                    copy_start <= 1'b0;
                    rect_q     <= '0;
                    slot_q     <= '0;
                    gpu_reset  <= start;
                    busy       <= start;
                    cyc_q      <= start ? CycW'(1) : '0;
                    if (start) begin
                        state_q <= StGpuRst;
                    end
                end
                StGpuRst: begin
                    state_q    <= StKick;
                    cyc_q      <= cyc_q + CycW'(1);
                    gpu_reset  <= 1'b0;
                    copy_start <= 1'b1;
                    // First table read coincides with the copy trigger.
                    mem_rd_en  <= 1'b1;
                    mem_addr   <= BASE_ADDR;
                    ptr_q      <= BASE_ADDR + ADDR_WIDTH'(1);
                    rect_q     <= '0;
                    slot_q     <= 3'd1;
                end
                StKick, StStream: begin
                    copy_start <= 1'b0;
                    cyc_q      <= cyc_q + CycW'(1);
                    if (slot_q < 3'd5 && rect_q < RectEnd) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= ptr_q;
                        ptr_q     <= ptr_q + ADDR_WIDTH'(1);
                    end else begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                    end
                    if (slot_q == 3'd5) begin
                        slot_q <= '0;
                        rect_q <= rect_q + RectW'(1);
                    end else begin
                        slot_q <= slot_q + 3'd1;
                    end
                    if (state_q == StKick) begin
                        state_q <= StStream;
                    end else if (cyc_q == LastCyc) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cyc_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data path: capture read data one cycle after each read strobe, zero otherwise.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rd_en_d_q <= 1'b0;
            data_out  <= '0;
        end else begin
            rd_en_d_q <= mem_rd_en;
            data_out  <= rd_en_d_q ? mem_rdata : 16'h0000;
        end
    end

endmodule

// File: tb/tb_rect_streamer.sv
// Bench for rect_streamer: directed timing checks plus randomized start/reset
// traffic compared against a slot-arithmetic reference model.
module tb_rect_streamer;

    localparam int          Base = 16'hFFF0;
    localparam int          NRect = 64;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        gpu_reset;
    logic        copy_start;
    logic [15:0] data_out;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: transfer active, offset from start sample, done pulse.
    bit m_active = 1'b0;
    int m_t = 0;
    bit m_done = 1'b0;
    bit pattern = 1'b0;

    logic        e_gpu, e_copy, e_rd, e_busy, e_done;
    logic [15:0] e_addr, e_data;

    int gpu_cnt, done_cnt;

    rect_streamer #(
        .ADDR_WIDTH(16),
        .BASE_ADDR (16'hFFF0),
        .RECT_COUNT(64)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .gpu_reset (gpu_reset),
        .copy_start(copy_start),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Synchronous memory: data valid the cycle after the strobe, garbage otherwise.
    always @(posedge pixel_clk) begin
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_t      = 1;
            end
        end else begin
            m_t++;
            if (m_t == 6 * NRect + 3) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic expect_outputs();
        int u, r, k;
        e_gpu = 1'b0; e_copy = 1'b0; e_rd = 1'b0; e_busy = 1'b0;
        e_addr = 16'h0; e_data = 16'h0; e_done = m_done;
        if (m_active) begin
            e_busy = 1'b1;
            e_gpu  = (m_t == 1);
            e_copy = (m_t == 2);
            u = m_t - 2;
            if (u >= 0) begin
                r = u / 6; k = u % 6;
                if (k < 5 && r < NRect) begin
                    e_rd   = 1'b1;
                    e_addr = 16'(Base + 5 * r + k);
                end
            end
            u = m_t - 4;
            if (u >= 0) begin
                r = u / 6; k = u % 6;
                if (k < 5 && r < NRect) e_data = mem[16'(Base + 5 * r + k)];
            end
        end
    endtask

    // Fixed expectations for the word-i = 16'h1000+i table.
    task automatic directed_checks();
        if (m_t == 1)   chk("gpu_reset_s1", gpu_reset, 1);
        if (m_t == 2)   chk("copy_start_s2", copy_start, 1);
        if (m_t == 2)   chk("addr_first", mem_addr, 16'hFFF0);
        if (m_t == 4)   chk("data_s4", data_out, 16'h1000);
        if (m_t == 8)   chk("data_s8", data_out, 16'h1004);
        if (m_t == 9)   chk("data_gap_s9", data_out, 16'h0000);
        if (m_t == 10)  chk("data_s10", data_out, 16'h1005);
        if (m_t == 20)  chk("addr_ffff", mem_addr, 16'hFFFF);
        if (m_t == 21)  chk("addr_wrap", mem_addr, 16'h0000);
        if (m_t == 384) chk("addr_last", mem_addr, 16'h012F);
        if (m_t == 386) chk("data_last", data_out, 16'h113F);
        if (m_t == 386) chk("busy_last", busy, 1);
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        cyc++;
        model_edge();
        #1;
        expect_outputs();
        chk("gpu_reset", gpu_reset, e_gpu);
        chk("copy_start", copy_start, e_copy);
        chk("mem_rd_en", mem_rd_en, e_rd);
        chk("mem_addr", mem_addr, e_addr);
        chk("data_out", data_out, e_data);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (pattern && m_active) directed_checks();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 320; i++) mem[16'(Base + i)] = 16'(16'h1000 + i);
        pattern = 1'b1;

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_data", data_out, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single transfer from a one-cycle start pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("single_done_count", done_cnt, 1);

        // Abort mid-transfer with reset, then restart.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (198) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (400) tick();

        // Start held high for 1000 cycles: back-to-back transfers.
        start = 1'b1;
        gpu_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (gpu_reset) gpu_cnt++;
            if (done) done_cnt++;
        end
        start = 1'b0;
        chk("held_transfers", gpu_cnt, 3);
        chk("held_done_count", done_cnt, 2);
        repeat (400) tick();

        // Randomized table contents and start/reset traffic.
        pattern = 1'b0;
        for (int i = 0; i < 320; i++) mem[16'(Base + i)] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (400) tick();
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rect_streamer.md
RECT_STREAMER -- requirements
Module: rect_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of the CPU data-memory address.
REQ-002 Parameter BASE_ADDR, default 0: address of word 0 of the rectangle table.
REQ-003 Parameter RECT_COUNT, default 64, fixed: the GPU loader leaves COPY only after rect index 63.
REQ-004 pixel_clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  transfer request; sampled only in IDLE.
REQ-007 mem_rdata  input  16  memory read data, valid one cycle after mem_rd_en/mem_addr.
REQ-008 mem_addr  output  ADDR_WIDTH  memory read address.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 gpu_reset  output  1  one-cycle reset pulse to the GPU loader.
REQ-011 copy_start  output  1  one-cycle copy trigger to the GPU loader.
REQ-012 data_out  output  16  word stream to the GPU mem_din.
REQ-013 busy  output  1  high while a transfer is in progress.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 Table layout: rect r at BASE_ADDR+5r+k, k = 0 x, 1 y, 2 width, 3 height, 4 color; 320 words total; address arithmetic is modulo 2^ADDR_WIDTH.
REQ-016 States: IDLE, GPU_RST, KICK, STREAM; IDLE->GPU_RST when start=1; GPU_RST->KICK unconditionally; KICK->STREAM unconditionally; STREAM->IDLE after the last capture slot.
REQ-017 Let S be the cycle in which start=1 is sampled in IDLE; gpu_reset=1 in cycle S+1 only.
REQ-018 copy_start=1 in cycle S+2 only, so that the GPU is in its idle READ_START slot in S+3.
REQ-019 The GPU capture slot for rect r, word k is cycle S+4+6r+k (r 0..63, k 0..4); data_out SHALL equal word BASE_ADDR+5r+k throughout that cycle.
REQ-020 The gap slots S+3+6r carry data_out=16'h0000; data_out is also 0 in IDLE, GPU_RST and KICK.
REQ-021 mem_rd_en=1 with mem_addr=BASE_ADDR+5r+k in cycle S+2+6r+k; otherwise mem_rd_en=0 and mem_addr=0.
REQ-022 data_out is a register loaded from mem_rdata in every cycle following a mem_rd_en=1 cycle, giving a fixed 2-cycle address-to-GPU latency.
REQ-023 busy=1 in cycles S+1 through S+386 inclusive; 0 otherwise.
REQ-024 done=1 in cycle S+387 only (state IDLE); the last capture (r=63, k=4) is cycle S+386.
REQ-025 start held or reasserted in the done cycle is sampled as a new S (back-to-back reload); start while busy is ignored and not queued.
REQ-026 Each transfer reloads the GPU from scratch via gpu_reset, so repeated transfers (e.g. once per frame) are legal.

Reset
REQ-027 While reset=1: state IDLE, counters 0, and all outputs 0 (mem_addr, mem_rd_en, gpu_reset, copy_start, data_out, busy, done) from the next edge.
REQ-028 Reset mid-transfer aborts immediately with no done pulse; the next start begins a full transfer including gpu_reset.

Verification
REQ-029 Memory model holds word i = 16'h1000+i; pulse start at S -> gpu_reset at S+1, copy_start at S+2, data_out=16'h1000 at S+4, 16'h1004 at S+8, 0 at S+9, 16'h1005 at S+10, 16'h113F at S+386, done at S+387.
REQ-030 Connect to the gpu block; table rect 0 = (10,20,30,40,16'h07E0), others zero-size -> after done, gpu rect 0 holds left 10, top 20, right 40, bottom 60, color 16'h07E0, and the gpu is in EXECUTE.
REQ-031 BASE_ADDR=16'hFFF0 -> first read at 16'hFFF0, wraps to 16'h0000 after 16 reads, last read 16'h012F.
REQ-032 start held high for 1000 cycles -> transfers start at S, S+387 and S+774; start pulses at S+100 are ignored; exactly one done pulse per 387 cycles.
REQ-033 reset asserted at S+200 for 1 cycle -> all outputs 0, no done; start at S+210 -> gpu_reset at S+211 and full timing per REQ-029.
